// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls a serial NES-style pad and publishes the button word.
// Latch/clock strobes are paced by a free-running poll counter and a phase counter.
module nes_pad_reader #(
    parameter int CLK_DIV     = 4,
    parameter int POLL_PERIOD = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] controller_data,
    output logic       data_valid,
    output logic       data_changed,
    output logic       busy
);

    localparam int CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int PW = $clog2(2 * CLK_DIV + 1);

    localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_PERIOD - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        READ_LO,
        READ_HI,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] poll_cnt;
    logic          tick;
    logic          pending;
    logic          start;
    logic          sync_meta;
    logic          sync_data;
    logic [7:0]    shift_reg;
    logic [7:0]    next_word;
    logic [2:0]    bit_idx;
    logic [PW-1:0] phase;

    assign tick  = (poll_cnt == POLL_LAST);
    assign start = pending | (tick & enable);

    // Two-flop synchronizer; idles high like an unpressed, pulled-up pad line
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_data <= 1'b1;
        end else begin
            sync_meta <= pad_data;
            sync_data <= sync_meta;
        end
    end

    // Free-running poll counter; the wrap cycle is the poll tick
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // Shift register with the current bit replaced by the inverted pad level
    always_comb begin
        next_word          = shift_reg;
        next_word[bit_idx] = ~sync_data;
    end

    // Frame sequencer with registered strobes and publish pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pending         <= 1'b0;
            shift_reg       <= 8'h00;
            bit_idx         <= 3'd0;
            phase           <= '0;
            pad_latch       <= 1'b0;
            pad_clk         <= 1'b0;
            controller_data <= 8'h00;
            data_valid      <= 1'b0;
            data_changed    <= 1'b0;
            busy            <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            data_changed <= 1'b0;
            if (tick && enable) begin
                pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pending   <= 1'b0;
                        state     <= LATCH;
                        phase     <= '0;
                        pad_latch <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LATCH: begin
                    if (phase == LATCH_LAST) begin
                        state     <= READ_LO;
                        phase     <= '0;
                        bit_idx   <= 3'd0;
                        pad_latch <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                READ_LO: begin
                    if (phase == HALF_LAST) begin
                        phase     <= '0;
                        shift_reg <= next_word;
                        if (bit_idx == 3'd7) begin
                            state           <= DONE;
                            controller_data <= next_word;
                            data_valid      <= 1'b1;
                            data_changed    <= (next_word != controller_data);
                        end else begin
                            state   <= READ_HI;
                            pad_clk <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                READ_HI: begin
                    if (phase == HALF_LAST) begin
                        state   <= READ_LO;
                        phase   <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        pad_clk <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: two pad readers (slow and back-to-back polling) against
// behavioural pad models, a word scoreboard and strobe timing monitors.
module tb_nes_pad_reader;

    localparam int T     = 4;
    localparam int PS    = 100;
    localparam int PF    = 10;
    localparam int FRAME = 17 * T + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       en0;
    logic       en1;
    logic [7:0] btn0;
    logic [7:0] btn1;
    logic [1:0] pad_data;
    logic [1:0] pad_latch;
    logic [1:0] pad_clk;
    logic [1:0] data_valid;
    logic [1:0] data_changed;
    logic [1:0] busy;
    logic [7:0] cdata [2];
    logic [7:0] btn   [2];

    int compared   = 0;
    int mismatched = 0;
    bit final_chk  = 1'b0;

    always #5 clk = ~clk;

    assign btn[0] = btn0;
    assign btn[1] = btn1;

    nes_pad_reader #(.CLK_DIV(T), .POLL_PERIOD(PS)) u_slow (
        .clk             (clk),
        .reset           (reset),
        .enable          (en0),
        .pad_data        (pad_data[0]),
        .pad_latch       (pad_latch[0]),
        .pad_clk         (pad_clk[0]),
        .controller_data (cdata[0]),
        .data_valid      (data_valid[0]),
        .data_changed    (data_changed[0]),
        .busy            (busy[0])
    );

    nes_pad_reader #(.CLK_DIV(T), .POLL_PERIOD(PF)) u_fast (
        .clk             (clk),
        .reset           (reset),
        .enable          (en1),
        .pad_data        (pad_data[1]),
        .pad_latch       (pad_latch[1]),
        .pad_clk         (pad_clk[1]),
        .controller_data (cdata[1]),
        .data_valid      (data_valid[1]),
        .data_changed    (data_changed[1]),
        .busy            (busy[1])
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : ch
        logic [7:0] snap = 8'h00;
        int         idx  = 8;
        logic [7:0] exp_q [$];
        logic [7:0] prev;
        logic [7:0] e;
        int         lat_run, clk_run, busy_run, pulses;
        logic       lat_q, clk_q, busy_q;
        bit         done_chk = 1'b0;

        // Pad: parallel load on latch, shift on each pad_clk rise
        always @(posedge pad_latch[g]) begin
            snap = btn[g];
            idx  = 0;
            exp_q.push_back(btn[g]);
        end

        always @(posedge pad_clk[g]) idx++;

        assign pad_data[g] = (idx < 8) ? ~snap[idx[2:0]] : 1'b0;

        // Scoreboard and strobe timing monitor
        always @(negedge clk) begin
            if (reset) begin
                exp_q.delete();
                prev     = 8'h00;
                lat_run  = 0;
                clk_run  = 0;
                busy_run = 0;
                pulses   = 0;
                lat_q    = 1'b0;
                clk_q    = 1'b0;
                busy_q   = 1'b0;
            end else begin
                if (pad_latch[g]) lat_run++;
                else if (lat_q) begin
                    check("latch_width", lat_run, 2 * T);
                    lat_run = 0;
                end
                if (pad_clk[g]) begin
                    if (!clk_q) pulses++;
                    clk_run++;
                end else if (clk_q) begin
                    check("clk_high", clk_run, T);
                    clk_run = 0;
                end
                if (busy[g]) busy_run++;
                else if (busy_q) begin
                    check("busy_len", busy_run, FRAME);
                    check("clk_pulses", pulses, 7);
                    busy_run = 0;
                    pulses   = 0;
                end
                lat_q  = pad_latch[g];
                clk_q  = pad_clk[g];
                busy_q = busy[g];
                if (data_valid[g]) begin
                    check("valid_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("word", cdata[g], e);
                        check("changed", data_changed[g], e != prev);
                        prev = e;
                    end
                end else begin
                    check("held", cdata[g], prev);
                    check("changed_alone", data_changed[g], 0);
                end
                if (final_chk && !done_chk) begin
                    check("leftover", exp_q.size(), 0);
                    done_chk = 1'b1;
                end
            end
        end
    end

    // Slow reader: a frame starts exactly on the cycle after an enabled tick
    int   cyc;
    logic en0_q, lat0_q, exp_rise, act_rise;
    always @(negedge clk) begin
        if (reset) begin
            cyc    = -1;
            en0_q  = 1'b0;
            lat0_q = 1'b0;
        end else begin
            cyc++;
            exp_rise = (cyc > 0) && (cyc % PS == 0) && en0_q;
            act_rise = pad_latch[0] && !lat0_q;
            if (exp_rise || act_rise) check("latch_start", act_rise, exp_rise);
            lat0_q = pad_latch[0];
            en0_q  = en0;
        end
    end

    // Fast reader: continuously enabled frames are separated by one idle cycle
    int   gap1;
    int   nfr1 = 0;
    logic busy1_q, had1, en_all1;
    always @(negedge clk) begin
        if (reset) begin
            gap1    = 0;
            had1    = 1'b0;
            busy1_q = 1'b0;
            en_all1 = 1'b1;
        end else begin
            en_all1 &= en1;
            if (!busy[1]) gap1++;
            else if (!busy1_q) begin
                nfr1++;
                if (had1 && en_all1) check("idle_gap", gap1, 1);
                had1    = 1'b1;
                gap1    = 0;
                en_all1 = en1;
            end
            busy1_q = busy[1];
        end
    end

    always @(negedge clk) begin
        if ($urandom_range(0, 7) == 0) btn1 = 8'($urandom);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_latch(input int c, input int lim);
        int k = 0;
        while (pad_latch[c] && k < lim) begin step(1); k++; end
        while (!pad_latch[c] && k < lim) begin step(1); k++; end
        check("latch_wait", 32'(k < lim), 1);
    endtask

    task automatic wait_idle(input int c, input int lim);
        int k = 0;
        while (busy[c] && k < lim) begin step(1); k++; end
        check("idle_wait", 32'(k < lim), 1);
    endtask

    task automatic wait_clks(input int n);
        int   k = 0;
        int   seen = 0;
        logic q = pad_clk[0];
        while (seen < n && k < 200) begin
            step(1);
            k++;
            if (pad_clk[0] && !q) seen++;
            q = pad_clk[0];
        end
        check("clk_wait", 32'(seen == n), 1);
    endtask

    task automatic wait_frame(input int c);
        wait_latch(c, 400);
        wait_idle(c, 200);
    endtask

    task automatic check_zero(input int c);
        check("reset_outs",
              {pad_latch[c], pad_clk[c], data_valid[c],
               data_changed[c], busy[c], cdata[c]}, 0);
    endtask

    int n0;

    initial begin
        reset = 1'b1;
        en0   = 1'b1;
        en1   = 1'b1;
        btn0  = 8'hC1;
        btn1  = 8'h00;
        step(2);
        check_zero(0);
        check_zero(1);
        reset = 1'b0;

        wait_frame(0);
        wait_frame(0);
        btn0 = 8'h00;
        wait_frame(0);

        repeat (6) begin
            if ($urandom_range(0, 3) != 0) btn0 = 8'($urandom);
            wait_frame(0);
        end

        en0 = 1'b0;
        step(3 * PS);

        en0  = 1'b1;
        btn0 = 8'h5A;
        wait_latch(0, 250);
        wait_clks(2);
        en0 = 1'b0;
        wait_idle(0, 200);
        step(250);

        en0  = 1'b1;
        btn0 = 8'($urandom);
        wait_latch(0, 250);
        wait_clks(4);
        reset = 1'b1;
        step(1);
        check_zero(0);
        check_zero(1);
        step(1);
        reset = 1'b0;
        btn0  = 8'($urandom) | 8'h01;
        wait_frame(0);

        wait_latch(1, 100);
        step(25);
        n0  = nfr1;
        en1 = 1'b0;
        step(400);
        check("drop_frames", nfr1 - n0, 1);

        en0 = 1'b0;
        step(200);
        final_chk = 1'b1;
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
